// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that hands one byte at a time from four
// requesters to a single UART transmitter and reports frame completion.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a WAIT_BUSY timeout
// counter and the o_Error pulse output.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_ReqData,
  input  logic [3*NUM_REQ-1:0] i_ReqCfg,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic [7:0]           o_TxData,
  output logic                 o_TxParityEn,
  output logic                 o_TxDatalength,
  output logic                 o_TxBaudrate,
  output logic                 o_TxWriteEnable,
  input  logic                 i_TxBusy,
  output logic                 o_Idle
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 o_Error
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } state_e;

  localparam logic [NUM_REQ-1:0] GrantLsb = NUM_REQ'(1);

  state_e     state;
  logic [1:0] ptr;        // round-robin start position
  logic [1:0] cur;        // requester owning the frame in flight
  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] cfg_base;
  logic [7:0] sel_data;
  logic [2:0] sel_cfg;
  logic       hold_off;
  logic       launch;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  logic [CntW-1:0] cnt;

  // The cycle after o_Done or o_Error is kept idle before the next selection.
  always_comb begin
    hold_off = (|o_Done) | o_Error;
  end
`else
  // Without the timeout the parameter only matters to builds that enable it;
  // a zero value is flagged as a visible scope in the elaborated hierarchy.
  if (BUSY_TIMEOUT == 0) begin : g_zero_busy_timeout
  end

  // The cycle after o_Done is kept idle before the next selection.
  always_comb begin
    hold_off = |o_Done;
  end
`endif

  // Round-robin pick: first requesting index at or after the pointer, wrapping 3->0.
  always_comb begin
    sel       = ptr;
    sel_valid = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!sel_valid && i_Req[ptr + 2'(i)]) begin
        sel       = ptr + 2'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // Byte and config slices of the selected requester; cfg_base = 3 * sel.
  always_comb begin
    cfg_base = {1'b0, sel, 1'b0} + {2'b00, sel};
    sel_data = i_ReqData[{sel, 3'b000} +: 8];
    sel_cfg  = i_ReqCfg[cfg_base +: 3];
  end

  // A busy transmitter or the post-completion idle cycle blocks a new grant.
  always_comb begin
    launch = sel_valid && !i_TxBusy && !hold_off;
  end

  // Arbitration FSM with registered grant, done, write strobe and Tx outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= StIdle;
      ptr             <= '0;
      cur             <= '0;
      o_Grant         <= '0;
      o_Done          <= '0;
      o_TxWriteEnable <= 1'b0;
      o_TxData        <= '0;
      o_TxBaudrate    <= 1'b0;
      o_TxDatalength  <= 1'b0;
      o_TxParityEn    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt             <= '0;
      o_Error         <= 1'b0;
`endif
    end else begin
      o_Grant         <= '0;
      o_Done          <= '0;
      o_TxWriteEnable <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      o_Error         <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (launch) begin
            state           <= StLaunch;
            cur             <= sel;
            o_Grant         <= GrantLsb << sel;
            o_TxWriteEnable <= 1'b1;
            o_TxData        <= sel_data;
            o_TxBaudrate    <= sel_cfg[2];
            o_TxDatalength  <= sel_cfg[1];
            o_TxParityEn    <= sel_cfg[0];
          end
        end
        StLaunch: begin
          state <= StWaitBusy;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        StWaitBusy: begin
          if (i_TxBusy) begin
            state <= StWaitDone;
`ifdef UART_TX_ARB_TIMEOUT_EN
          end else if (cnt == CntLast) begin
            // Transmitter never accepted the byte: drop it and move past cur.
            o_Error <= 1'b1;
            ptr     <= cur + 2'd1;
            state   <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        StWaitDone: begin
          if (!i_TxBusy) begin
            o_Done <= GrantLsb << cur;
            ptr    <= cur + 2'd1;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Idle flag decoded from the state register.
  always_comb begin
    o_Idle = (state == StIdle);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven bench for uart_tx_arbiter plus
// hand-written sequences for reset, busy and (if enabled) timeout corners.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic [11:0] cfg;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [2:0]  exp_cfg;   // {baud, length, parity}
    logic        drop;      // release i_Req once granted
  } vec_t;

  logic        clock;
  logic        reset;
  logic [3:0]  i_Req;
  logic [31:0] i_ReqData;
  logic [11:0] i_ReqCfg;
  logic [3:0]  o_Grant;
  logic [3:0]  o_Done;
  logic [7:0]  o_TxData;
  logic        o_TxParityEn;
  logic        o_TxDatalength;
  logic        o_TxBaudrate;
  logic        o_TxWriteEnable;
  logic        i_TxBusy;
  logic        o_Idle;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        o_Error;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_Req           (i_Req),
    .i_ReqData       (i_ReqData),
    .i_ReqCfg        (i_ReqCfg),
    .o_Grant         (o_Grant),
    .o_Done          (o_Done),
    .o_TxData        (o_TxData),
    .o_TxParityEn    (o_TxParityEn),
    .o_TxDatalength  (o_TxDatalength),
    .o_TxBaudrate    (o_TxBaudrate),
    .o_TxWriteEnable (o_TxWriteEnable),
    .i_TxBusy        (i_TxBusy),
    .o_Idle          (o_Idle)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .o_Error         (o_Error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " grant"}, 32'(o_Grant), 32'd0);
    check({tag, " done"}, 32'(o_Done), 32'd0);
    check({tag, " we"}, 32'(o_TxWriteEnable), 32'd0);
    check({tag, " data"}, 32'(o_TxData), 32'd0);
    check({tag, " cfg"}, 32'({o_TxBaudrate, o_TxDatalength, o_TxParityEn}), 32'd0);
    check({tag, " idle"}, 32'(o_Idle), 32'd1);
  endtask

  // Advance to the next negedge, then poll (bounded) for a grant.
  task automatic wait_grant(output int n);
    n = 0;
    @(negedge clock);
    while (o_Grant == 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Called in the LAUNCH cycle: run the transmitter through a short busy burst.
  task automatic finish_frame(input logic [3:0] exp_done, input string tag);
    int n;
    i_TxBusy = 1'b1;
    @(negedge clock);
    check({tag, " pulse"}, 32'({o_Grant, o_TxWriteEnable}), 32'd0);
    repeat (2) @(negedge clock);
    i_TxBusy = 1'b0;
    n = 0;
    @(negedge clock);
    while (o_Done == 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, " done"}, 32'(o_Done), 32'(exp_done));
    @(negedge clock);
    check({tag, " gap"}, 32'({o_Done, o_Grant, o_Idle}), 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n;
    i_Req     = v.req;
    i_ReqData = v.data;
    i_ReqCfg  = v.cfg;
    wait_grant(n);
    check({tag, " grant"}, 32'(o_Grant), 32'(v.exp_grant));
    check({tag, " latency"}, 32'(n), 32'd0);
    check({tag, " we"}, 32'(o_TxWriteEnable), 32'd1);
    check({tag, " data"}, 32'(o_TxData), 32'(v.exp_data));
    check({tag, " cfg"}, 32'({o_TxBaudrate, o_TxDatalength, o_TxParityEn}),
          32'(v.exp_cfg));
    if (v.drop) i_Req = 4'b0000;
    finish_frame(v.exp_grant, tag);
    check({tag, " hold"}, 32'(o_TxData), 32'(v.exp_data));
  endtask

  vec_t vecs [13];

  initial begin
    int   n;
    logic [3:0] acc;
    vec_t v;

    // Round-robin from reset with all four held, then pointer wrap and singles.
    vecs[0]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h1, 8'h11, 3'b001, 1'b0};
    vecs[1]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h2, 8'h22, 3'b010, 1'b0};
    vecs[2]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h4, 8'h33, 3'b011, 1'b0};
    vecs[3]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h8, 8'h44, 3'b100, 1'b0};
    vecs[4]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h1, 8'h11, 3'b001, 1'b0};
    vecs[5]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h2, 8'h22, 3'b010, 1'b0};
    vecs[6]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h4, 8'h33, 3'b011, 1'b0};
    vecs[7]  = '{4'hF, 32'h44332211, 12'h8D1, 4'h8, 8'h44, 3'b100, 1'b1};
    vecs[8]  = '{4'h9, 32'hC3000096, 12'h606, 4'h1, 8'h96, 3'b110, 1'b0};
    vecs[9]  = '{4'h9, 32'hC3000096, 12'h606, 4'h8, 8'hC3, 3'b011, 1'b1};
    vecs[10] = '{4'h2, 32'h0000A500, 12'h028, 4'h2, 8'hA5, 3'b101, 1'b1};
    vecs[11] = '{4'h1, 32'h0000005A, 12'h002, 4'h1, 8'h5A, 3'b010, 1'b1};
    vecs[12] = '{4'h5, 32'h00E70000, 12'h1C0, 4'h4, 8'hE7, 3'b111, 1'b1};

    reset     = 1'b0;
    i_Req     = 4'b0000;
    i_ReqData = 32'h0;
    i_ReqCfg  = 12'h0;
    i_TxBusy  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("por error", 32'(o_Error), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Requests that come and go outside IDLE must never be granted. Pointer is 3.
    i_Req     = 4'b0001;
    i_ReqData = 32'h00000011;
    i_ReqCfg  = 12'h000;
    wait_grant(n);
    check("stray grant0", 32'(o_Grant), 32'h1);
    i_Req    = 4'b0000;
    i_TxBusy = 1'b1;
    repeat (2) @(negedge clock);
    i_Req = 4'b0100;
    repeat (2) @(negedge clock);
    i_Req    = 4'b0000;
    i_TxBusy = 1'b0;
    n = 0;
    @(negedge clock);
    while (o_Done == 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stray done", 32'(o_Done), 32'h1);
    acc = 4'b0000;
    repeat (4) begin
      @(negedge clock);
      acc = acc | o_Grant;
    end
    check("stray none", 32'(acc), 32'd0);
    check("stray idle", 32'(o_Idle), 32'd1);

    // Reset during WAIT_DONE: immediate reset values, no o_Done, pointer back to 0.
    i_Req     = 4'b0100;
    i_ReqData = 32'h00BB0000;
    i_ReqCfg  = 12'h1C0;
    wait_grant(n);
    check("rst grant", 32'(o_Grant), 32'h4);
    i_Req    = 4'b0000;
    i_TxBusy = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst async");
    i_TxBusy = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    acc = 4'b0000;
    repeat (3) begin
      @(negedge clock);
      acc = acc | o_Done;
    end
    check("rst no done", 32'(acc), 32'd0);
    v = '{4'hA, 32'h55006600, 12'h018, 4'h2, 8'h66, 3'b011, 1'b1};
    run_frame(v, "rst after");

    // Busy already high out of reset holds off the grant until it falls.
    @(negedge clock);
    reset     = 1'b0;
    i_TxBusy  = 1'b1;
    i_Req     = 4'b0001;
    i_ReqData = 32'h0000003C;
    i_ReqCfg  = 12'h004;
    @(negedge clock);
    reset = 1'b1;
    acc = 4'b0000;
    repeat (6) begin
      @(negedge clock);
      acc = acc | o_Grant;
    end
    check("busy blocked", 32'(acc), 32'd0);
    check("busy idle", 32'(o_Idle), 32'd1);
    i_TxBusy = 1'b0;
    @(negedge clock);
    check("busy grant", 32'(o_Grant), 32'h1);
    check("busy data", 32'(o_TxData), 32'h3C);
    check("busy cfg", 32'({o_TxBaudrate, o_TxDatalength, o_TxParityEn}), 32'b100);
    i_Req = 4'b0000;
    finish_frame(4'b0001, "busy");

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Transmitter never goes busy: o_Error after 16 WAIT_BUSY cycles, pointer moves on.
    i_Req     = 4'b0010;
    i_ReqData = 32'h00004200;
    i_ReqCfg  = 12'h008;
    wait_grant(n);
    check("tmo grant", 32'(o_Grant), 32'h2);
    i_Req = 4'b0000;
    n = 0;
    acc = 4'b0000;
    do begin
      @(negedge clock);
      n++;
      acc = acc | o_Done;
    end while (!o_Error && n < 40);
    check("tmo cycles", 32'(n), 32'd17);
    check("tmo no done", 32'(acc), 32'd0);
    check("tmo idle", 32'(o_Idle), 32'd1);
    @(negedge clock);
    check("tmo pulse", 32'(o_Error), 32'd0);
    i_Req     = 4'b0101;
    i_ReqData = 32'h00D20000;
    i_ReqCfg  = 12'h040;
    wait_grant(n);
    check("tmo next", 32'(o_Grant), 32'h4);
    i_Req = 4'b0000;
    finish_frame(4'b0100, "tmo");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
